// File: rtl/mod_mult_pipe_if.sv
// Operand/result port group between the scalar-multiplier sequencer and the
// GF(2^255-19) multiplier pipeline.
interface mod_mult_pipe_if;
    logic [255:0] mult_in_0;
    logic [255:0] mult_in_1;
    logic         mult_in_valid;
    logic [254:0] mult_out;
    logic         mult_out_valid;

    modport master (
        output mult_in_0,
        output mult_in_1,
        output mult_in_valid,
        input  mult_out,
        input  mult_out_valid
    );

    modport slave (
        input  mult_in_0,
        input  mult_in_1,
        input  mult_in_valid,
        output mult_out,
        output mult_out_valid
    );
endinterface

// File: rtl/mod_mult_pipe.sv
// Fully pipelined (A*B) mod (2^255-19): one operand pair per clock, canonical
// product 13 clocks later, with a valid tag riding alongside each slot.
module mod_mult_pipe (
    input  logic           clk,
    input  logic           rst,
    mod_mult_pipe_if.slave mult_bus
);
    localparam logic [255:0] P_MOD =
        256'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFED;
    localparam int unsigned  NDIG  = 8;
    localparam int unsigned  LAT   = 13;

    // One Horner step: shift in a 32-bit digit of B, then fold bits >= 255
    // back in using 2^255 == 19 (mod p). Result stays below 2^256.
    function automatic logic [255:0] horner_step(
        input logic [255:0] acc,
        input logic [255:0] a,
        input logic [31:0]  d
    );
        logic [288:0] t;
        t = {1'b0, acc, 32'd0} + 289'(a) * 289'(d);
        return 256'(t[254:0]) + 256'(t[288:255]) * 256'(19);
    endfunction

    // a_q/b_q[j]: operands held by stage S(j+1); acc_q[j]: accumulator out of S(j+1)
    logic [255:0] a_q   [0:NDIG-1];
    logic [255:0] b_q   [0:NDIG-1];
    logic [255:0] acc_q [1:NDIG];
    logic [255:0] acc_d [1:NDIG];
    logic [255:0] a0_d;
    logic [255:0] b0_d;
    logic [255:0] r10_q;
    logic [255:0] r10_d;
    logic [254:0] r11_q;
    logic [254:0] r11_d;
    logic [254:0] r12_q;
    logic [254:0] r13_q;
    logic         vld_q [1:LAT];

    always_comb begin
        // Idle slots are zeroed so undriven operands never enter the datapath.
        a0_d = mult_bus.mult_in_valid ? mult_bus.mult_in_0 : '0;
        b0_d = mult_bus.mult_in_valid ? mult_bus.mult_in_1 : '0;

        acc_d[1] = horner_step('0, a_q[0], b_q[0][255:224]);
        for (int j = 2; j <= NDIG; j++) begin
            acc_d[j] = horner_step(acc_q[j-1], a_q[j-1], b_q[j-1][32*(NDIG-j) +: 32]);
        end

        r10_d = 256'(acc_q[NDIG][254:0]) + (acc_q[NDIG][255] ? 256'd19 : 256'd0);
        r11_d = (r10_q >= P_MOD) ? 255'(r10_q - P_MOD) : r10_q[254:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NDIG; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
            end
            for (int i = 1; i <= NDIG; i++) begin
                acc_q[i] <= '0;
            end
            for (int i = 1; i <= LAT; i++) begin
                vld_q[i] <= 1'b0;
            end
            r10_q <= '0;
            r11_q <= '0;
            r12_q <= '0;
            r13_q <= '0;
        end else begin
            a_q[0]   <= a0_d;
            b_q[0]   <= b0_d;
            vld_q[1] <= mult_bus.mult_in_valid;
            for (int i = 1; i < NDIG; i++) begin
                a_q[i] <= a_q[i-1];
                b_q[i] <= b_q[i-1];
            end
            for (int i = 1; i <= NDIG; i++) begin
                acc_q[i] <= acc_d[i];
            end
            for (int i = 2; i <= LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
            r10_q <= r10_d;
            r11_q <= r11_d;
            // S12/S13 are pure retiming after the wide compare/subtract.
            r12_q <= r11_q;
            r13_q <= r12_q;
        end
    end

    assign mult_bus.mult_out       = r13_q;
    assign mult_bus.mult_out_valid = vld_q[LAT];

endmodule

// File: tb/tb_mod_mult_pipe.sv
// Directed and random checks of mod_mult_pipe against a 512-bit (A*B) % p
// reference, with per-slot expectations queued at issue time.
module tb_mod_mult_pipe;
    localparam logic [255:0] P =
        256'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFED;

    typedef struct {
        int           due;
        logic         v;
        logic [254:0] d;
        string        tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    mod_mult_pipe_if mif ();

    mod_mult_pipe dut (
        .clk      (clk),
        .rst      (rst),
        .mult_bus (mif)
    );

    function automatic logic [254:0] ref_mul(input logic [255:0] a, input logic [255:0] b);
        logic [511:0] pr;
        pr = {256'd0, a} * {256'd0, b};
        return 255'(pr % {256'd0, P});
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        if ($urandom_range(0, 15) == 0) r = '1;
        return r;
    endfunction

    task automatic push_exp(input int due, input logic v, input logic [254:0] d, input string tag);
        exp_t e;
        e.due = due;
        e.v   = v;
        e.d   = d;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic check_due();
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                checks++;
                assert (mif.mult_out_valid === sb[i].v && mif.mult_out === sb[i].d)
                else begin
                    errors++;
                    $error("FAIL %s cyc=%0d got v=%0b d=%h exp v=%0b d=%h",
                           sb[i].tag, cyc, mif.mult_out_valid, mif.mult_out, sb[i].v, sb[i].d);
                end
                sb.delete(i);
            end
        end
    endtask

    // Drive one cycle; r=1 means a reset cycle (output must be 0/0 right after
    // the edge and the slot itself must come out empty).
    task automatic step(input logic [255:0] a, input logic [255:0] b, input logic v,
                        input logic r, input logic ev, input logic [254:0] ed,
                        input string tag, input bit track = 1'b1);
        mif.mult_in_0     = a;
        mif.mult_in_1     = b;
        mif.mult_in_valid = v;
        rst               = r;
        if (track) begin
            if (r) push_exp(cyc + 1, 1'b0, '0, {tag, "_rstout"});
            push_exp(cyc + 13, r ? 1'b0 : ev, r ? 255'd0 : ed, tag);
        end
        @(posedge clk);
        #1;
        cyc++;
        check_due();
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step('0, '0, 1'b0, 1'b0, 1'b0, '0, tag);
    endtask

    initial begin
        logic [255:0] pm1;
        logic [255:0] ra;
        logic [255:0] rb;
        logic         rv;
        int           n;
        pm1 = P - 256'd1;

        step('0, '0, 1'b0, 1'b1, 1'b0, '0, "reset");
        step('0, '0, 1'b0, 1'b1, 1'b0, '0, "reset");
        idle(13, "idle0");

        step(256'd3, 256'd5, 1'b1, 1'b0, 1'b1, 255'd15, "basic");
        idle(14, "basic_idle");

        step(pm1, pm1, 1'b1, 1'b0, 1'b1, 255'd1, "pm1_sq");
        step({1'b1, 255'd0}, 256'd2, 1'b1, 1'b0, 1'b1, 255'd38, "2p255x2");
        step('1, 256'd1, 1'b1, 1'b0, 1'b1, 255'd37, "allones");
        step(P, 256'd7, 1'b1, 1'b0, 1'b1, 255'd0, "p_x7");
        idle(14, "corner_idle");

        step(256'd2, 256'd3, 1'b1, 1'b0, 1'b1, 255'd6, "sweep0");
        step(256'd4, 256'd5, 1'b1, 1'b0, 1'b1, 255'd20, "sweep1");
        step(pm1, 256'd2, 1'b1, 1'b0, 1'b1, 255'(P - 256'd2), "sweep2");
        step(256'd0, 256'd9, 1'b1, 1'b0, 1'b1, 255'd0, "sweep3");
        idle(14, "sweep_idle");

        step(256'd7, 256'd8, 1'b1, 1'b0, 1'b1, 255'd56, "bub0");
        step('x, 'x, 1'b0, 1'b0, 1'b0, 255'd0, "bubble");
        step(256'd9, 256'd10, 1'b1, 1'b0, 1'b1, 255'd90, "bub2");
        idle(14, "bubble_idle");

        for (int i = 0; i < 5; i++)
            step(256'(i + 100), 256'(i + 200), 1'b1, 1'b0, 1'b0, 255'd0, "flushed");
        idle(1, "pre_rst");
        step(256'd5, 256'd6, 1'b1, 1'b1, 1'b0, 255'd0, "midrst");
        step(256'd5, 256'd6, 1'b1, 1'b1, 1'b0, 255'd0, "midrst");
        step(256'd11, 256'd13, 1'b1, 1'b0, 1'b1, 255'd143, "post_rst");
        idle(14, "post_rst_idle");

        for (int i = 0; i < 10000; i++) begin
            ra = rnd256();
            rb = rnd256();
            rv = ($urandom_range(0, 3) != 0);
            step(ra, rb, rv, 1'b0, rv, rv ? ref_mul(ra, rb) : 255'd0, "rand");
        end

        idle(14, "drain");
        n = 0;
        while (sb.size() > 0 && n < 20) begin
            step('0, '0, 1'b0, 1'b0, 1'b0, '0, "flush", 1'b0);
            n++;
        end
        checks++;
        assert (sb.size() == 0)
        else begin
            errors++;
            $error("FAIL drain left=%0d required=0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mod_mult_pipe.md
# mod_mult_pipe

Fully pipelined modular multiplier over GF(p), p = 2^255 − 19. It is the responder behind the scalar multiplier's mult_in_0 / mult_in_1 / mult_out port group. It accepts one operand pair per clock and returns the fully reduced product exactly 13 cycles later, which matches the fixed issue-to-capture distance used by the point-addition sequencer. An optional valid tag travels with each operand pair so benches and future arbiters can track the slots that are in flight.

## Interface
- No parameters. Latency is fixed at 13 and the digit width is fixed at 32.
- clk  input  1  Single clock; all state updates on the rising edge.
- rst  input  1  Synchronous, active-high reset.
- mult_in_0  input  256  Operand A, any value 0..2^256−1 (need not be reduced).
- mult_in_1  input  256  Operand B, any value 0..2^256−1.
- mult_in_valid  input  1  Qualifies the operands. Scalar-mult integration ties it high.
- mult_out  output  255  (A·B) mod p, canonical (< p).
- mult_out_valid  output  1  High when mult_out carries the result of a valid issue.

## Operation
- Stage S1: input capture.
  - mult_in_valid=1: register A, B and the valid bit.
  - mult_in_valid=0: register A=0, B=0 and valid=0. This stops X values from an idle caller propagating into the pipeline.
- Stages S2–S9: MSB-first Horner accumulation over the eight 32-bit digits of B. Digit k=7 is handled in S2 and digit k=0 in S9.
  - Each stage computes t = (acc << 32) + A·d_k, with acc=0 entering S2.
  - The stage then folds: acc' = t[254:0] + 19·t[288:255].
  - Bound: acc' < 2^256 at every stage. Internal acc registers are 256 bits; t is 289 bits.
- S10: final fold r = acc[254:0] + 19·acc[255]; r < 2^255 + 19.
- S11: canonicalise r' = (r ≥ p) ? r − p : r, giving r' < p.
- S12–S13: retime registers (timing slack for the 255-bit carry chains); S13 drives mult_out.
- The valid bit shifts alongside the data through all 13 stages.
- No flow control and no back-pressure: the block accepts an operand pair every cycle unconditionally. Results leave in strict issue order.
- Invalid slots compute 0·0, so mult_out=0 and mult_out_valid=0 for those slots.

## Timing
- Latency: operands present before edge n produce a result visible after edge n+13.
  - Example: issue in the cycle where the sequencer counter reads 16; capture in the cycle where it reads 3.
- Throughput: 1 product per clock. Up to 13 products can be in flight.
- Reset:
  - While rst=1 at an edge, every pipeline data register and every valid bit clears to 0.
  - As a result, mult_out=0 and mult_out_valid=0 from the first edge with rst high.
  - The operands present during a reset cycle are not captured.
- Reset mid-operation: all in-flight products are discarded. No valid output appears for any issue made before or during the reset cycles.
- After reset deasserts: the first operands captured are those present at the first edge with rst=0. Their result appears 13 edges later. Outputs stay 0/0 until then.
- Valid bubbles: a 0 on mult_in_valid produces exactly one output cycle with valid=0 and data=0, at the matching position.
- Wrap/overflow: operands ≥ p, up to 2^256−1, are legal. Products are always reduced fully. No overflow flag exists.

## Test plan
- Basic: issue A=3, B=5, valid=1 at cycle 0 → mult_out=15, valid=1 at cycle 13. Valid must be 0 at cycles 1–12 and at cycle 14.
- Reduction corners (each product checked 13 cycles after its own issue):
  - (p−1)·(p−1) → 1
  - 2^255·2 → 38
  - (2^256−1)·1 → 37
  - p·7 → 0
- Back-to-back sweep (scalar-mult pattern): issue four pairs (2,3), (4,5), (p−1,2), (0,9) on consecutive cycles 0–3 → cycles 13–16 show 6, 20, p−2, 0 with valid=1 on all four.
- Bubble and X gating: issue at cycle 0, drive X operands with valid=0 at cycle 1, issue again at cycle 2 → cycle 14 shows mult_out=0 with valid=0 and no X on mult_out. Cycles 13 and 15 show the correct products.
- Reset mid-flight:
  - Issue at cycles 0–4; assert rst during cycles 6–7 → no valid result in cycles 13–17; mult_out=0 from cycle 7.
  - Issue 11·13 at cycle 8 → 143 with valid at cycle 21.
- Random regression: 10,000 random 256-bit pairs at full rate with random valid, compared against a big-integer model of (A·B) mod p, including order and the 13-cycle alignment.
